// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: steps {A,B,C} through 000..111 for the combinational unit under test,
// holds each vector SETTLE_CYCLES cycles, samples F at the end of each hold and compares the
// captured table against a latched expected table. Results hold in DONE until the next start.
module truth_table_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] exp_tt,
    input  logic       f_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic [2:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic [7:0] cap_tt,
    output logic [7:0] err_mask,
    output logic [3:0] err_count,
    output logic       pass
);

    // Settle counter runs 0..LastCount; the edge where it sits at LastCount ends the hold.
    localparam logic [7:0] LastCount = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] MaxErrors = 4'd8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } stateT;

    stateT      stateQ, stateD;
    logic [2:0] vecQ, vecD;
    logic [7:0] settleQ, settleD;
    logic [7:0] expQ, expD;
    logic [7:0] capQ, capD;
    logic [7:0] errQ, errD;
    logic [3:0] errCntQ, errCntD;

    logic       lastCycle;
    logic       mismatch;

    assign lastCycle = (settleQ == LastCount);
    // Compare against the table latched at start so mid-run exp_tt changes are invisible.
    assign mismatch  = f_in ^ expQ[vecQ];

    // Next-state logic: accept start from IDLE/DONE, otherwise advance the sweep.
    always_comb begin
        stateD  = stateQ;
        vecD    = vecQ;
        settleD = settleQ;
        expD    = expQ;
        capD    = capQ;
        errD    = errQ;
        errCntD = errCntQ;

        unique case (stateQ)
            StIdle, StDone: begin
                if (start) begin
                    stateD  = StRun;
                    expD    = exp_tt;
                    capD    = 8'h00;
                    errD    = 8'h00;
                    errCntD = 4'd0;
                    vecD    = 3'd0;
                    settleD = 8'd0;
                end
            end
            StRun: begin
                if (lastCycle) begin
                    settleD       = 8'd0;
                    capD[vecQ]    = f_in;
                    errD[vecQ]    = mismatch;
                    // Each vector is sampled once, so the count is bounded; the guard keeps it
                    // from ever wrapping regardless.
                    if (mismatch && (errCntQ < MaxErrors)) begin
                        errCntD = errCntQ + 4'd1;
                    end
                    if (vecQ == 3'd7) begin
                        vecD   = 3'd0;
                        stateD = StDone;
                    end else begin
                        vecD = vecQ + 3'd1;
                    end
                end else begin
                    settleD = settleQ + 8'd1;
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // State and result registers; synchronous reset clears everything, aborting any sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= StIdle;
            vecQ    <= 3'd0;
            settleQ <= 8'd0;
            expQ    <= 8'h00;
            capQ    <= 8'h00;
            errQ    <= 8'h00;
            errCntQ <= 4'd0;
        end else begin
            stateQ  <= stateD;
            vecQ    <= vecD;
            settleQ <= settleD;
            expQ    <= expD;
            capQ    <= capD;
            errQ    <= errD;
            errCntQ <= errCntD;
        end
    end

    // Outputs decoded from registered state; vector pins are forced low outside RUN.
    always_comb begin
        busy                  = (stateQ == StRun);
        done                  = (stateQ == StDone);
        vec_idx               = busy ? vecQ : 3'd0;
        {a_out, b_out, c_out} = vec_idx;
        cap_tt                = capQ;
        err_mask              = errQ;
        err_count             = errCntQ;
        pass                  = done && (errCntQ == 4'd0);
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: one instance at the default settle time and one at
// SETTLE_CYCLES=1, each driving a modelled combinational unit whose truth table is unitTt.
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       startA, startB;
    logic [7:0] expTt;
    logic [7:0] unitTt;
    logic       fInA, fInB;

    logic       aA, bA, cA, busyA, doneA, passA;
    logic [2:0] vecA;
    logic [7:0] capA, errA;
    logic [3:0] cntA;
    logic       aB, bB, cB, busyB, doneB, passB;
    logic [2:0] vecB;
    logic [7:0] capB, errB;
    logic [3:0] cntB;

    always #5 clk = ~clk;

    // The unit under test is just a lookup on the pins the sequencer drives.
    assign fInA = unitTt[{aA, bA, cA}];
    assign fInB = unitTt[{aB, bB, cB}];

    truth_table_sequencer #(.SETTLE_CYCLES(4)) dutA (
        .clk(clk), .rst(rst), .start(startA), .exp_tt(expTt), .f_in(fInA),
        .a_out(aA), .b_out(bA), .c_out(cA), .vec_idx(vecA), .busy(busyA), .done(doneA),
        .cap_tt(capA), .err_mask(errA), .err_count(cntA), .pass(passA)
    );

    truth_table_sequencer #(.SETTLE_CYCLES(1)) dutB (
        .clk(clk), .rst(rst), .start(startB), .exp_tt(expTt), .f_in(fInB),
        .a_out(aB), .b_out(bB), .c_out(cB), .vec_idx(vecB), .busy(busyB), .done(doneB),
        .cap_tt(capB), .err_mask(errB), .err_count(cntB), .pass(passB)
    );

    // sel picks which instance the sweep helpers drive and observe.
    bit         sel;
    logic [2:0] vecS, abcS;
    logic       busyS, doneS, passS;
    logic [7:0] capS, errS;
    logic [3:0] cntS;
    assign vecS  = sel ? vecB : vecA;
    assign abcS  = sel ? {aB, bB, cB} : {aA, bA, cA};
    assign busyS = sel ? busyB : busyA;
    assign doneS = sel ? doneB : doneA;
    assign passS = sel ? passB : passA;
    assign capS  = sel ? capB : capA;
    assign errS  = sel ? errB : errA;
    assign cntS  = sel ? cntB : cntA;

    int nCompared = 0;
    int nMismatch = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        nCompared++;
        if (act !== want) begin
            nMismatch++;
            $display("FAIL %s (sel=%0d t=%0t): got %0h, want %0h", name, sel, $time, act, want);
        end
    endtask

    // Reference: captured table is the unit's table; a bit is in error where it differs
    // from the expected table; pass means no differing entries.
    task automatic model(input logic [7:0] e, input logic [7:0] u, output logic [7:0] wCap,
                         output logic [7:0] wErr, output logic [3:0] wCnt, output logic wPass);
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            wCap[i] = u[i];
            wErr[i] = (u[i] != e[i]);
            if (u[i] != e[i]) n++;
        end
        wCnt  = 4'(n);
        wPass = (n == 0);
    endtask

    task automatic pulseStart(input logic [7:0] e, input logic [7:0] u);
        unitTt = u;
        expTt  = e;
        if (sel) startB = 1'b1;
        else startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_A"}, {aA, bA, cA, vecA, busyA, doneA, capA, errA, cntA, passA}, 32'd0);
        check({tag, "_B"}, {aB, bB, cB, vecB, busyB, doneB, capB, errB, cntB, passB}, 32'd0);
    endtask

    // Full sweep on the selected instance, with optional mid-run restart and exp_tt change.
    task automatic doSweep(input logic [7:0] e, input logic [7:0] u, input int againAt,
                           input int expAt, input logic [7:0] expNew, input logic [7:0] wCap,
                           input logic [7:0] wErr, input logic [3:0] wCnt, input logic wPass);
        int s = sel ? 1 : 4;
        int total = 8 * s;
        pulseStart(e, u);
        check("accept_busy", busyS, 1);
        check("accept_done", doneS, 0);
        check("accept_vec", vecS, 0);
        check("accept_clear", {capS, errS, cntS, passS}, 0);
        for (int k = 1; k < total; k++) begin
            if (k == againAt) begin
                if (sel) startB = 1'b1;
                else startA = 1'b1;
            end
            if (k == expAt) expTt = expNew;
            @(negedge clk);
            startA = 1'b0;
            startB = 1'b0;
            check("run_vec", vecS, 32'(k / s));
            check("run_abc", abcS, 32'(k / s));
            check("run_busy_done", {busyS, doneS}, 2'b10);
        end
        @(negedge clk);
        check("end_busy_done", {busyS, doneS}, 2'b01);
        check("end_vec_abc", {vecS, abcS}, 0);
        check("end_cap", capS, wCap);
        check("end_err", errS, wErr);
        check("end_cnt", cntS, wCnt);
        check("end_pass", passS, wPass);
        for (int h = 0; h < 3; h++) begin
            expTt  = 8'($urandom);
            unitTt = 8'($urandom);
            @(negedge clk);
            check("hold", {doneS, capS, errS, cntS, passS}, {1'b1, wCap, wErr, wCnt, wPass});
        end
    endtask

    typedef struct {
        bit         sel;
        logic [7:0] e;
        logic [7:0] u;
        int         againAt;
        int         expAt;
        logic [7:0] expNew;
        logic [7:0] wCap;
        logic [7:0] wErr;
        logic [3:0] wCnt;
        logic       wPass;
    } vecT;

    vecT tbl[8];

    initial begin
        logic [7:0] e, u, mCap, mErr;
        logic [3:0] mCnt;
        logic       mPass;
        int         again, expAt;

        tbl[0] = '{1'b0, 8'h5B, 8'h5B, -1, -1, 8'h00, 8'h5B, 8'h00, 4'd0, 1'b1};
        tbl[1] = '{1'b0, 8'h5B, 8'h00, -1, -1, 8'h00, 8'h00, 8'h5B, 4'd5, 1'b0};
        tbl[2] = '{1'b0, 8'h5B, 8'h1B, -1, -1, 8'h00, 8'h1B, 8'h40, 4'd1, 1'b0};
        tbl[3] = '{1'b0, 8'h5B, 8'h5B, 5, 12, 8'hFF, 8'h5B, 8'h00, 4'd0, 1'b1};
        tbl[4] = '{1'b1, 8'h5B, 8'h5B, -1, -1, 8'h00, 8'h5B, 8'h00, 4'd0, 1'b1};
        tbl[5] = '{1'b1, 8'h5B, 8'h00, 3, 2, 8'hFF, 8'h00, 8'h5B, 4'd5, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 8'hFF, -1, -1, 8'h00, 8'hFF, 8'hFF, 4'd8, 1'b0};
        tbl[7] = '{1'b1, 8'hFF, 8'h00, -1, -1, 8'h00, 8'h00, 8'hFF, 4'd8, 1'b0};

        sel    = 1'b0;
        rst    = 1'b1;
        startA = 1'b0;
        startB = 1'b0;
        expTt  = 8'h00;
        unitTt = 8'h00;
        repeat (2) @(negedge clk);
        checkZero("reset");
        rst = 1'b0;
        @(negedge clk);
        checkZero("idle");

        // start and rst on the same edge: rst wins, both stay idle.
        startA = 1'b1;
        startB = 1'b1;
        rst    = 1'b1;
        expTt  = 8'h5B;
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
        rst    = 1'b0;
        checkZero("start_rst");
        @(negedge clk);
        checkZero("start_rst_after");

        for (int t = 0; t < 8; t++) begin
            sel = tbl[t].sel;
            doSweep(tbl[t].e, tbl[t].u, tbl[t].againAt, tbl[t].expAt, tbl[t].expNew,
                    tbl[t].wCap, tbl[t].wErr, tbl[t].wCnt, tbl[t].wPass);
        end

        // rst during cycle 10 of a sweep aborts it; a fresh sweep then completes normally.
        sel = 1'b0;
        pulseStart(8'h5B, 8'h5B);
        repeat (9) @(negedge clk);
        check("mid_cap", capS, 8'h03);
        check("mid_vec", vecS, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkZero("abort");
        doSweep(8'h5B, 8'h5B, -1, -1, 8'h00, 8'h5B, 8'h00, 4'd0, 1'b1);

        for (int it = 0; it < 24; it++) begin
            sel   = bit'($urandom_range(0, 1));
            e     = 8'($urandom);
            u     = ($urandom_range(0, 3) == 0) ? e : 8'($urandom);
            again = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, sel ? 7 : 31)) : -1;
            expAt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, sel ? 7 : 31)) : -1;
            model(e, u, mCap, mErr, mCnt, mPass);
            doSweep(e, u, again, expAt, 8'($urandom), mCap, mErr, mCnt, mPass);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
